// File: rtl/ber_checker_mc.sv
`default_nettype none
// ============================================================================
// ber_checker_mc : multi-lane self-synchronising PRBS bit-error-rate checker
// Rev 1.0
// ============================================================================
module ber_checker_mc #(
  parameter int NCH     = 4,
  parameter int RECV_W  = 58,
  parameter int ERR_W   = 64,
  parameter int LOCK_N  = 64,
  parameter int WIN_W   = 10,
  parameter int LOSS_TH = 128
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic [NCH-1:0]    DIN,
  input  logic [NCH-1:0]    DIN_VLD,
  input  logic [1:0]        MODE,
  input  logic              CLR,
  input  logic [3:0]        SEL,
  output logic [NCH-1:0]    LOCK,
  output logic [NCH-1:0]    LOSS,
  output logic [RECV_W-1:0] RECV_CNT,
  output logic [ERR_W-1:0]  ERR_CNT
);

  localparam int MATCH_W = $clog2(LOCK_N + 1);
  localparam int WERR_W  = $clog2(LOSS_TH + 1);
  localparam logic [MATCH_W-1:0] C_LOCK_N  = MATCH_W'(LOCK_N);
  localparam logic [WERR_W-1:0]  C_LOSS_TH = WERR_W'(LOSS_TH);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  logic [1:0]        mode_d, mode_q;
  logic              mode_chg;
  logic [RECV_W-1:0] lane_recv [NCH];
  logic [ERR_W-1:0]  lane_err  [NCH];
  logic [RECV_W-1:0] recv_cnt_d, recv_cnt_q;
  logic [ERR_W-1:0]  err_cnt_d, err_cnt_q;

  always_comb mode_d = MODE;
  assign mode_chg = (MODE != mode_q);

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) mode_q <= '0;
    else       mode_q <= mode_d;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    state_t             state_d, state_q;
    logic [30:0]        sr_d, sr_q;
    logic [MATCH_W-1:0] match_d, match_q;
    logic [WIN_W-1:0]   win_d, win_q, win_inc;
    logic [WERR_W-1:0]  werr_d, werr_q, werr_inc;
    logic [RECV_W-1:0]  recv_d, recv_q;
    logic [ERR_W-1:0]   err_d, err_q;
    logic               loss_d, loss_q;
    logic               pred, err_bit;

    always_comb begin
      case (MODE)
        2'd0:    pred = sr_q[6]  ^ sr_q[5];
        2'd1:    pred = sr_q[14] ^ sr_q[13];
        2'd2:    pred = sr_q[22] ^ sr_q[17];
        default: pred = sr_q[30] ^ sr_q[27];
      endcase
    end

    assign err_bit  = pred ^ DIN[g];
    assign win_inc  = win_q + 1'b1;
    assign werr_inc = werr_q + WERR_W'(err_bit);

    always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      match_d = match_q;
      win_d   = win_q;
      werr_d  = werr_q;
      recv_d  = recv_q;
      err_d   = err_q;
      loss_d  = loss_q;
      if (DIN_VLD[g]) begin
        if (state_q == ST_HUNT) begin
          sr_d = {sr_q[29:0], DIN[g]};
          if (match_q == C_LOCK_N) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = err_bit ? '0 : match_q + 1'b1;
          end
        end else begin
          // Regenerate from our own prediction so one bad bit is counted once.
          sr_d   = {sr_q[29:0], pred};
          recv_d = (&recv_q) ? recv_q : recv_q + 1'b1;
          if (err_bit && !(&err_q)) err_d = err_q + 1'b1;
          win_d = win_inc;
          if (werr_inc == C_LOSS_TH) begin
            state_d = ST_HUNT;
            match_d = '0;
            werr_d  = '0;
            loss_d  = 1'b1;
          end else if (win_inc == '0) begin
            werr_d = '0;
          end else begin
            werr_d = werr_inc;
          end
        end
      end
      if (mode_chg) begin
        state_d = ST_HUNT;
        match_d = '0;
        win_d   = '0;
        werr_d  = '0;
        recv_d  = '0;
        err_d   = '0;
        loss_d  = loss_q;
      end
      if (CLR) begin
        recv_d = '0;
        err_d  = '0;
        loss_d = 1'b0;
      end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
        state_q <= ST_HUNT;
        sr_q    <= '0;
        match_q <= '0;
        win_q   <= '0;
        werr_q  <= '0;
        recv_q  <= '0;
        err_q   <= '0;
        loss_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        sr_q    <= sr_d;
        match_q <= match_d;
        win_q   <= win_d;
        werr_q  <= werr_d;
        recv_q  <= recv_d;
        err_q   <= err_d;
        loss_q  <= loss_d;
      end
    end

    assign LOCK[g]      = (state_q == ST_LOCKED);
    assign LOSS[g]      = loss_q;
    assign lane_recv[g] = recv_q;
    assign lane_err[g]  = err_q;
  end

  // Out-of-range SEL matches no lane and leaves the outputs at zero.
  always_comb begin
    recv_cnt_d = '0;
    err_cnt_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (SEL == 4'(i)) begin
        recv_cnt_d = lane_recv[i];
        err_cnt_d  = lane_err[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      recv_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      recv_cnt_q <= recv_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign RECV_CNT = recv_cnt_q;
  assign ERR_CNT  = err_cnt_q;

endmodule
`default_nettype wire
